// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: width defaults, ALU/result-mux encodings
// and the packed E-stage control bundle.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_IMM = 2'd3
    } result_src_e;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        alu_op_e     alu_ctrl;
        logic        alu_src;
    } ctrl_e_t;

endpackage

// File: rtl/id_ex_pipe_if.sv
// D-stage inputs, stall/flush controls and E-stage outputs of the ID/EX register.
// Counter outputs exist only when ID_EX_PIPE_PERF_EN is defined.
interface id_ex_pipe_if #(
    parameter int XLEN = riscv_pkg::XLEN_DEF,
    parameter int REGW = riscv_pkg::REGW_DEF
);
    logic            StallE, FlushE;
    logic            ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]      ResultSrcD;
    logic [2:0]      ALUControlD;
    logic [XLEN-1:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
    logic [REGW-1:0] Rs1D, Rs2D, RdD;

    logic            ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [REGW-1:0] Rs1E, Rs2E, RdE;
`ifdef ID_EX_PIPE_PERF_EN
    logic [31:0]     BubbleCntE, StallCntE;
`endif

    modport master (
        output StallE, FlushE,
        output ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
        output ResultSrcD, ALUControlD,
        output RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD,
        input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        input  ResultSrcE, ALUControlE,
`ifdef ID_EX_PIPE_PERF_EN
        input  BubbleCntE, StallCntE,
`endif
        input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE
    );

    modport slave (
        input  StallE, FlushE,
        input  ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
        input  ResultSrcD, ALUControlD,
        input  RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD,
        output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        output ResultSrcE, ALUControlE,
`ifdef ID_EX_PIPE_PERF_EN
        output BubbleCntE, StallCntE,
`endif
        output RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE
    );

endinterface

// File: rtl/id_ex_pipe_flop.sv
// Enable/clear register used for each ID/EX field group; clear wins over enable.
module pipe_flop #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= d;
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: one-cycle capture with stall hold and flush bubble.
// Define ID_EX_PIPE_PERF_EN to add bubble/stall event counters.
module id_ex_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input logic         clk,
    input logic         reset,
    id_ex_pipe_if.slave bus
);

    localparam int NDATA = 5;
    localparam int NREG  = 3;

    logic                      en, clr;
    ctrl_e_t                   ctrl_d, ctrl_q;
    logic [NDATA-1:0][XLEN-1:0] data_d, data_q;
    logic [NREG-1:0][REGW-1:0]  radr_d, radr_q;

    assign en  = ~bus.StallE;
    assign clr = bus.FlushE;

    always_comb begin
        ctrl_d            = '0;
        ctrl_d.valid      = bus.ValidD;
        ctrl_d.reg_write  = bus.RegWriteD;
        ctrl_d.result_src = result_src_e'(bus.ResultSrcD);
        ctrl_d.mem_write  = bus.MemWriteD;
        ctrl_d.jump       = bus.JumpD;
        ctrl_d.branch     = bus.BranchD;
        ctrl_d.alu_ctrl   = alu_op_e'(bus.ALUControlD);
        ctrl_d.alu_src    = bus.ALUSrcD;
    end

    assign data_d = {bus.PCPlus4D, bus.ImmExtD, bus.PCD, bus.RD2D, bus.RD1D};
    assign radr_d = {bus.RdD, bus.Rs2D, bus.Rs1D};

    pipe_flop #(.WIDTH($bits(ctrl_e_t))) u_ctrl (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .d(ctrl_d), .q(ctrl_q)
    );

    // One flop per datapath word keeps each field's enable/clear fanout local.
    for (genvar i = 0; i < NDATA; i++) begin : g_data
        pipe_flop #(.WIDTH(XLEN)) u_data (
            .clk(clk), .reset(reset), .en(en), .clr(clr), .d(data_d[i]), .q(data_q[i])
        );
    end

    for (genvar i = 0; i < NREG; i++) begin : g_radr
        pipe_flop #(.WIDTH(REGW)) u_radr (
            .clk(clk), .reset(reset), .en(en), .clr(clr), .d(radr_d[i]), .q(radr_q[i])
        );
    end

    assign bus.ValidE      = ctrl_q.valid;
    assign bus.RegWriteE   = ctrl_q.reg_write;
    assign bus.ResultSrcE  = ctrl_q.result_src;
    assign bus.MemWriteE   = ctrl_q.mem_write;
    assign bus.JumpE       = ctrl_q.jump;
    assign bus.BranchE     = ctrl_q.branch;
    assign bus.ALUControlE = ctrl_q.alu_ctrl;
    assign bus.ALUSrcE     = ctrl_q.alu_src;

    assign bus.RD1E     = data_q[0];
    assign bus.RD2E     = data_q[1];
    assign bus.PCE      = data_q[2];
    assign bus.ImmExtE  = data_q[3];
    assign bus.PCPlus4E = data_q[4];

    assign bus.Rs1E = radr_q[0];
    assign bus.Rs2E = radr_q[1];
    assign bus.RdE  = radr_q[2];

`ifdef ID_EX_PIPE_PERF_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;

    // Flush takes priority, so a simultaneous stall counts only as a bubble.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q + 32'(bus.FlushE);
        stall_cnt_d  = stall_cnt_q + 32'(bus.StallE & ~bus.FlushE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.BubbleCntE = bubble_cnt_q;
    assign bus.StallCntE  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: stimulus pushes expected E state, monitor pops/compares.
// Counter checks compile only with ID_EX_PIPE_PERF_EN.
module tb_id_ex_pipe;

    typedef struct packed {
        logic        v, rw, mw, j, b, as;
        logic [1:0]  rs;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, pc, imm, pc4;
        logic [4:0]  rs1, rs2, rd;
    } st_t;

    typedef struct packed {
        st_t         vec;
        logic [31:0] bub, stl;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    id_ex_pipe_if #(.XLEN(32), .REGW(5)) bus ();
    id_ex_pipe #(.XLEN(32), .REGW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    st_t  model;
    logic [31:0] m_bub, m_stl;

    function automatic st_t read_e();
        st_t s;
        s.v = bus.ValidE; s.rw = bus.RegWriteE; s.mw = bus.MemWriteE;
        s.j = bus.JumpE; s.b = bus.BranchE; s.as = bus.ALUSrcE;
        s.rs = bus.ResultSrcE; s.alu = bus.ALUControlE;
        s.rd1 = bus.RD1E; s.rd2 = bus.RD2E; s.pc = bus.PCE;
        s.imm = bus.ImmExtE; s.pc4 = bus.PCPlus4E;
        s.rs1 = bus.Rs1E; s.rs2 = bus.Rs2E; s.rd = bus.RdE;
        return s;
    endfunction

    task automatic drive_d(input st_t s);
        bus.ValidD = s.v; bus.RegWriteD = s.rw; bus.MemWriteD = s.mw;
        bus.JumpD = s.j; bus.BranchD = s.b; bus.ALUSrcD = s.as;
        bus.ResultSrcD = s.rs; bus.ALUControlD = s.alu;
        bus.RD1D = s.rd1; bus.RD2D = s.rd2; bus.PCD = s.pc;
        bus.ImmExtD = s.imm; bus.PCPlus4D = s.pc4;
        bus.Rs1D = s.rs1; bus.Rs2D = s.rs2; bus.RdD = s.rd;
    endtask

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference: bubble on flush, hold on stall, otherwise take D.
    task automatic step(input st_t d, input bit stall, input bit flush);
        bus.StallE = stall;
        bus.FlushE = flush;
        drive_d(d);
        @(posedge clk);
        if (flush) begin
            model = '0;
            m_bub = m_bub + 1;
        end else if (stall) begin
            m_stl = m_stl + 1;
        end else begin
            model = d;
        end
        sb.push_back('{vec: model, bub: m_bub, stl: m_stl});
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges, with stall and flush both held high.
    task automatic mid_reset(input st_t d);
        bus.StallE = 1'b1;
        bus.FlushE = 1'b1;
        drive_d(d);
        #2 reset = 1'b1;
        #1;
        chk("reset_async_e", 192'(read_e()), 192'(0));
`ifdef ID_EX_PIPE_PERF_EN
        chk("reset_async_cnt", 192'({bus.BubbleCntE, bus.StallCntE}), 192'(0));
`endif
        model = '0; m_bub = '0; m_stl = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_estate", 192'(read_e()), 192'(e.vec));
`ifdef ID_EX_PIPE_PERF_EN
                chk("sb_bubble_cnt", 192'(bus.BubbleCntE), 192'(e.bub));
                chk("sb_stall_cnt", 192'(bus.StallCntE), 192'(e.stl));
`endif
            end
        end
    end

    function automatic st_t rnd_st();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[$bits(st_t)-1:0];
    endfunction

    initial begin : stim
        st_t d;
        model = '0; m_bub = '0; m_stl = '0;
        bus.StallE = 1'b0; bus.FlushE = 1'b0;
        d = '0; d.pc = 32'h0000_0040; d.v = 1'b1;
        drive_d(d);
        #1;
        chk("reset_init_e", 192'(read_e()), 192'(0));
        @(negedge clk);
        reset = 1'b0;

        // Pass-through
        d = '0; d.pc = 32'h0000_0100; d.rd = 5'd7; d.rw = 1'b1; d.v = 1'b1;
        step(d, 1'b0, 1'b0);
        chk("pass_pc", 192'(bus.PCE), 192'(32'h0000_0100));
        chk("pass_rd_rw_v", 192'({bus.RdE, bus.RegWriteE, bus.ValidE}), 192'({5'd7, 1'b1, 1'b1}));

        // Stall holds the earlier capture
        d.pc = 32'h104;
        step(d, 1'b0, 1'b0);
        d.pc = 32'h108;
        for (int i = 0; i < 3; i++) step(d, 1'b1, 1'b0);
        chk("stall_pc_hold", 192'(bus.PCE), 192'(32'h104));
`ifdef ID_EX_PIPE_PERF_EN
        chk("stall_cnt_3", 192'(bus.StallCntE), 192'(3));
`endif

        // Flush loads a bubble
        d = rnd_st(); d.mw = 1'b1; d.v = 1'b1;
        step(d, 1'b0, 1'b1);
        chk("flush_mw_v_pc", 192'({bus.MemWriteE, bus.ValidE, bus.PCE}), 192'(0));
`ifdef ID_EX_PIPE_PERF_EN
        chk("flush_bubble_1", 192'(bus.BubbleCntE), 192'(1));
`endif

        // Flush beats stall
        d = rnd_st(); step(d, 1'b0, 1'b0);
        d = rnd_st(); step(d, 1'b1, 1'b1);
        chk("prio_bubble", 192'(read_e()), 192'(0));
`ifdef ID_EX_PIPE_PERF_EN
        chk("prio_cnts", 192'({bus.BubbleCntE, bus.StallCntE}), 192'({32'd2, 32'd3}));
`endif

        // ValidD=0 keeps control bits unmasked
        d = rnd_st(); d.v = 1'b0; d.rw = 1'b1; d.mw = 1'b1; d.j = 1'b1; d.b = 1'b1;
        step(d, 1'b0, 1'b0);
        chk("invalid_ctrl_kept", 192'({bus.ValidE, bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE}),
            192'(5'b01111));

`ifdef ID_EX_PIPE_PERF_EN
        // Counter wrap
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        m_stl = 32'hFFFF_FFFF;
        step(d, 1'b1, 1'b0);
        chk("stall_cnt_wrap", 192'(bus.StallCntE), 192'(0));
`endif

        for (int i = 0; i < 300; i++)
            step(rnd_st(), ($urandom_range(3) == 0), ($urandom_range(7) == 0));

        // Reset over a stall+flush, then a normal capture
        mid_reset(rnd_st());
        d = rnd_st();
        step(d, 1'b0, 1'b0);
        chk("post_reset_capture", 192'(read_e()), 192'(d));

        for (int i = 0; i < 100; i++)
            step(rnd_st(), ($urandom_range(3) == 0), ($urandom_range(7) == 0));

        @(posedge clk);
        #2;
        chk("sb_drained", 192'(sb.size()), 192'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
